datamem_arbiter: RTL and testbench

Shares the single-port CPU data memory between two requesters: the CPU load/store path and the hash accelerator's memory port.
- The CPU side is driven by the decoder's datamem_read_en/datamem_write_en.
- One transaction is outstanding at a time.
- Fair round-robin arbitration, with a bounded burst lock for the accelerator.
- All outputs are registered; read data returns with a valid pulse.

---
 rtl/datamem_arbiter_if.sv | 51 +++++
 rtl/datamem_arbiter.sv | 127 ++++++++++++
 tb/tb_datamem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_arbiter_if.sv
// Bundle of requester, memory and status signals around the data-memory arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface datamem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          acc_req;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_lock;
  logic          acc_gnt;
  logic          acc_rvalid;
  logic [DW-1:0] acc_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  acc_req, acc_we, acc_addr, acc_wdata, acc_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output acc_gnt, acc_rvalid, acc_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output acc_req, acc_we, acc_addr, acc_wdata, acc_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  acc_gnt, acc_rvalid, acc_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Shares the single-port data memory between the CPU and the hash accelerator.
// One transaction in flight, round-robin with a bounded accelerator burst lock.
module datamem_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  datamem_arbiter_if.slave bus
);
  localparam int unsigned LW = $clog2(MEM_LAT + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          r_state;
  logic            r_last_acc;
  logic [BW-1:0]   r_burst_cnt;
  logic [LW-1:0]   r_lat_cnt;
  logic            r_cpu_gnt, r_acc_gnt, r_cpu_rvalid, r_acc_rvalid;
  logic [DW-1:0]   r_cpu_rdata, r_acc_rdata;
  logic            r_mem_en, r_mem_we, r_busy;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;

  logic            w_lock_active;
  logic            w_pick_acc;
  logic [BW-1:0]   w_burst_inc;

  // A non-zero burst count means the previous grant was a locked accelerator grant.
  assign w_lock_active = bus.acc_lock && (r_burst_cnt != '0) &&
                         (r_burst_cnt < BW'(MAX_BURST));
  assign w_burst_inc   = (r_burst_cnt == BW'(MAX_BURST)) ? r_burst_cnt
                                                          : r_burst_cnt + BW'(1);

  always_comb begin
    w_pick_acc = 1'b0;
    if (bus.acc_req && !bus.cpu_req) begin
      w_pick_acc = 1'b1;
    end else if (bus.acc_req && bus.cpu_req) begin
      w_pick_acc = w_lock_active ? 1'b1 : !r_last_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_last_acc   <= 1'b1;
      r_burst_cnt  <= '0;
      r_lat_cnt    <= '0;
      r_cpu_gnt    <= 1'b0;
      r_acc_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_acc_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_acc_rdata  <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_cpu_gnt    <= 1'b0;
      r_acc_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_acc_rvalid <= 1'b0;
      r_mem_en     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.cpu_req || bus.acc_req) begin
            r_state     <= StIssue;
            r_busy      <= 1'b1;
            r_last_acc  <= w_pick_acc;
            r_mem_en    <= 1'b1;
            r_cpu_gnt   <= !w_pick_acc;
            r_acc_gnt   <= w_pick_acc;
            r_mem_we    <= w_pick_acc ? bus.acc_we    : bus.cpu_we;
            r_mem_addr  <= w_pick_acc ? bus.acc_addr  : bus.cpu_addr;
            r_mem_wdata <= w_pick_acc ? bus.acc_wdata : bus.cpu_wdata;
            r_burst_cnt <= (w_pick_acc && bus.acc_lock) ? w_burst_inc : '0;
          end
        end
        StIssue: begin
          if (r_mem_we) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= StWait;
            r_lat_cnt <= LW'(MEM_LAT);
          end
        end
        StWait: begin
          r_lat_cnt <= r_lat_cnt - LW'(1);
          if (r_lat_cnt == LW'(1)) begin
            r_state <= StResp;
            if (r_last_acc) begin
              r_acc_rdata  <= bus.mem_rdata;
              r_acc_rvalid <= 1'b1;
            end else begin
              r_cpu_rdata  <= bus.mem_rdata;
              r_cpu_rvalid <= 1'b1;
            end
          end
        end
        StResp: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.cpu_gnt    = r_cpu_gnt;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.acc_gnt    = r_acc_gnt;
  assign bus.acc_rvalid = r_acc_rvalid;
  assign bus.acc_rdata  = r_acc_rdata;
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_datamem_arbiter.sv
// Scoreboard bench for datamem_arbiter: one DUT with MEM_LAT=1 for arbitration
// and read/write flows, a second with MEM_LAT=3 for the longer read latency.
module tb_datamem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  datamem_arbiter_if #(.AW(16), .DW(32)) b1 ();
  datamem_arbiter_if #(.AW(16), .DW(32)) b3 ();

  datamem_arbiter #(.AW(16), .DW(32), .MEM_LAT(1), .MAX_BURST(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  datamem_arbiter #(.AW(16), .DW(32), .MEM_LAT(3), .MAX_BURST(4)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.slave)
  );

  typedef struct packed {
    logic        acc;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    logic        acc;
    logic [31:0] data;
  } rd_t;

  gnt_t exp_g[$];
  rd_t  exp_r[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   cpu_hold = 1'b0;
  bit   acc_hold = 1'b0;

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    if (a == 16'h0020) return 32'h1234_5678;
    if (a == 16'h0030) return 32'hFEED_F00D;
    return {16'h5EED, a};
  endfunction

  // Memory models: read data is only meaningful in the cycle it is due.
  logic        v1 = 1'b0;
  logic [31:0] rd1 = '0;
  logic [2:0]  v3 = '0;
  logic [31:0] rd3 [3];
  assign b1.mem_rdata = v1 ? rd1 : 32'hBAD0_BAD0;
  assign b3.mem_rdata = v3[2] ? rd3[2] : 32'hBAD3_BAD3;

  always @(posedge clk) begin
    v1     <= b1.mem_en && !b1.mem_we;
    rd1    <= mem_val(b1.mem_addr);
    v3     <= {v3[1:0], b3.mem_en && !b3.mem_we};
    rd3[0] <= mem_val(b3.mem_addr);
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every grant and every read response is matched against the queues.
  always @(negedge clk) begin
    if (b1.cpu_gnt || b1.acc_gnt) begin
      if (exp_g.size() == 0) begin
        chk("unexpected_gnt", {b1.cpu_gnt, b1.acc_gnt}, 2'b00);
      end else begin
        gnt_t e;
        e = exp_g.pop_front();
        chk("gnt_txn",
            {b1.cpu_gnt, b1.acc_gnt, b1.mem_en, b1.mem_we, b1.mem_addr,
             (e.we ? b1.mem_wdata : 32'h0)},
            {!e.acc, e.acc, 1'b1, e.we, e.addr, (e.we ? e.wdata : 32'h0)});
      end
    end else if (b1.mem_en) begin
      chk("stray_mem_en", b1.mem_en, 1'b0);
    end
    if (b1.cpu_rvalid || b1.acc_rvalid) begin
      if (exp_r.size() == 0) begin
        chk("unexpected_rvalid", {b1.cpu_rvalid, b1.acc_rvalid}, 2'b00);
      end else begin
        rd_t r;
        r = exp_r.pop_front();
        chk("rd_resp",
            {b1.cpu_rvalid, b1.acc_rvalid, (r.acc ? b1.acc_rdata : b1.cpu_rdata)},
            {!r.acc, r.acc, r.data});
      end
    end
  end

  // Advance one cycle; a granted requester either moves to its next write or drops req.
  task automatic step();
    @(negedge clk);
    if (b1.cpu_gnt) begin
      if (cpu_hold) begin
        b1.cpu_addr  = b1.cpu_addr + 16'd1;
        b1.cpu_wdata = 32'hC0DE_0000 | 32'(b1.cpu_addr);
      end else begin
        b1.cpu_req = 1'b0;
      end
    end
    if (b1.acc_gnt) begin
      if (acc_hold) begin
        b1.acc_addr  = b1.acc_addr + 16'd1;
        b1.acc_wdata = 32'hACC0_0000 | 32'(b1.acc_addr);
      end else begin
        b1.acc_req = 1'b0;
      end
    end
  endtask

  task automatic push_wr(input logic acc, input logic [15:0] a);
    exp_g.push_back('{acc: acc, we: 1'b1, addr: a,
                      wdata: (acc ? 32'hACC0_0000 : 32'hC0DE_0000) | 32'(a)});
  endtask

  function automatic logic [118:0] all_out1();
    return {b1.cpu_gnt, b1.cpu_rvalid, b1.cpu_rdata, b1.acc_gnt, b1.acc_rvalid,
            b1.acc_rdata, b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.busy};
  endfunction

  function automatic logic [118:0] all_out3();
    return {b3.cpu_gnt, b3.cpu_rvalid, b3.cpu_rdata, b3.acc_gnt, b3.acc_rvalid,
            b3.acc_rdata, b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata, b3.busy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_cnt;
    rst_n = 1'b1;
    {b1.cpu_req, b1.cpu_we, b1.cpu_addr, b1.cpu_wdata} = '0;
    {b1.acc_req, b1.acc_we, b1.acc_addr, b1.acc_wdata, b1.acc_lock} = '0;
    {b3.cpu_req, b3.cpu_we, b3.cpu_addr, b3.cpu_wdata} = '0;
    {b3.acc_req, b3.acc_we, b3.acc_addr, b3.acc_wdata, b3.acc_lock} = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_outs_dut1", all_out1(), '0);
    chk("reset_outs_dut3", all_out3(), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // CPU write alone
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 16'h0010; b1.cpu_wdata = 32'hDEAD_BEEF;
    exp_g.push_back('{acc: 1'b0, we: 1'b1, addr: 16'h0010, wdata: 32'hDEAD_BEEF});
    step();
    chk("t1_gnt_busy", {b1.cpu_gnt, b1.acc_gnt, b1.busy}, 3'b101);
    step();
    chk("t1_idle_t2", {b1.busy, b1.mem_en}, 2'b00);

    // CPU read, one-cycle memory
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 16'h0020; b1.cpu_wdata = '0;
    exp_g.push_back('{acc: 1'b0, we: 1'b0, addr: 16'h0020, wdata: 32'h0});
    exp_r.push_back('{acc: 1'b0, data: 32'h1234_5678});
    step();
    chk("t2_gnt", b1.cpu_gnt, 1'b1);
    step();
    chk("t2_wait", {b1.cpu_rvalid, b1.busy}, 2'b01);
    step();
    chk("t2_rvalid", {b1.cpu_rvalid, b1.cpu_rdata}, {1'b1, 32'h1234_5678});
    chk("t2_acc_rdata", b1.acc_rdata, 32'h0);
    step();
    chk("t2_idle", {b1.cpu_rvalid, b1.busy}, 2'b00);

    // Reset in the middle of a CPU read
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 16'h0020;
    exp_g.push_back('{acc: 1'b0, we: 1'b0, addr: 16'h0020, wdata: 32'h0});
    step();
    chk("t6_gnt", b1.cpu_gnt, 1'b1);
    step();
    chk("t6_in_wait", b1.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outs", all_out1(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      rv_cnt += int'(b1.cpu_rvalid) + int'(b1.busy);
    end
    chk("t6_no_rvalid", rv_cnt, 0);

    // Both requesting, no lock: CPU first after reset, then alternate
    cpu_hold = 1'b1; acc_hold = 1'b1;
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 16'h0100; b1.cpu_wdata = 32'hC0DE_0100;
    b1.acc_req = 1'b1; b1.acc_we = 1'b1; b1.acc_addr = 16'h0200; b1.acc_wdata = 32'hACC0_0200;
    push_wr(1'b0, 16'h0100); push_wr(1'b1, 16'h0200);
    push_wr(1'b0, 16'h0101); push_wr(1'b1, 16'h0201);
    repeat (8) step();
    chk("t3_drained", exp_g.size(), 0);

    // Locked accelerator burst capped at four while the CPU waits
    b1.acc_lock  = 1'b1;
    b1.cpu_addr  = 16'h0300; b1.cpu_wdata = 32'hC0DE_0300;
    b1.acc_addr  = 16'h0400; b1.acc_wdata = 32'hACC0_0400;
    push_wr(1'b0, 16'h0300);
    push_wr(1'b1, 16'h0400); push_wr(1'b1, 16'h0401);
    push_wr(1'b1, 16'h0402); push_wr(1'b1, 16'h0403);
    push_wr(1'b0, 16'h0301);
    push_wr(1'b1, 16'h0404); push_wr(1'b1, 16'h0405);
    repeat (16) step();
    b1.cpu_req = 1'b0; b1.acc_req = 1'b0; b1.acc_lock = 1'b0;
    cpu_hold = 1'b0; acc_hold = 1'b0;
    repeat (3) step();
    chk("t4_drained", exp_g.size(), 0);

    // Accelerator read with three-cycle memory
    b3.acc_req = 1'b1; b3.acc_we = 1'b0; b3.acc_addr = 16'h0030;
    rv_cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      rv_cnt += int'(b3.acc_rvalid);
      if (c == 1) begin
        chk("t5_issue", {b3.acc_gnt, b3.cpu_gnt, b3.mem_en, b3.mem_we, b3.mem_addr},
            {4'b1010, 16'h0030});
        b3.acc_req = 1'b0;
      end
      if (c == 4) chk("t5_before_capture", {b3.acc_rvalid, b3.acc_rdata}, 33'h0);
      if (c == 5) chk("t5_rvalid", {b3.acc_rvalid, b3.acc_rdata}, {1'b1, 32'hFEED_F00D});
      if (c == 7) chk("t5_idle", {b3.busy, b3.acc_rdata}, {1'b0, 32'hFEED_F00D});
    end
    chk("t5_one_pulse", rv_cnt, 1);
    chk("t5_cpu_rdata", b3.cpu_rdata, 32'h0);

    chk("final_gnt_queue", exp_g.size(), 0);
    chk("final_rd_queue", exp_r.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
